// File: rtl/core_mem_arbiter.sv
// Two-requester round-robin arbiter for the core req/gnt/rvalid memory
// protocol. Shares one downstream port between m0 (fetch) and m1 (data),
// holds an ungranted selection stable, and routes each downstream rvalid
// back to its issuer through an in-order ID FIFO.
//
// Ports:
//   clk_i, rst_ni                 clock, synchronous active-low reset
//   mX_req_i/gnt_o/rvalid_o       per-requester handshake (X = 0, 1)
//   mX_addr_i/we_i/be_i/wdata_i   per-requester command
//   mX_rdata_o                    read data, both driven from s_rdata_i
//   s_req_o/gnt_i/rvalid_i        downstream handshake
//   s_addr_o/we_o/be_o/wdata_o    command muxed from the selected requester
//   s_rdata_i                     downstream read data
//   err_o                         sticky: response arrived with no ID pending
module core_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  m0_req_i,
  output logic                  m0_gnt_o,
  output logic                  m0_rvalid_o,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic                  m0_we_i,
  input  logic [3:0]            m0_be_i,
  input  logic [DATA_WIDTH-1:0] m0_wdata_i,
  output logic [DATA_WIDTH-1:0] m0_rdata_o,
  input  logic                  m1_req_i,
  output logic                  m1_gnt_o,
  output logic                  m1_rvalid_o,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic                  m1_we_i,
  input  logic [3:0]            m1_be_i,
  input  logic [DATA_WIDTH-1:0] m1_wdata_i,
  output logic [DATA_WIDTH-1:0] m1_rdata_o,
  output logic                  s_req_o,
  input  logic                  s_gnt_i,
  input  logic                  s_rvalid_i,
  output logic [ADDR_WIDTH-1:0] s_addr_o,
  output logic                  s_we_o,
  output logic [3:0]            s_be_o,
  output logic [DATA_WIDTH-1:0] s_wdata_o,
  input  logic [DATA_WIDTH-1:0] s_rdata_i,
  output logic                  err_o
);

  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e                     state_q;
  logic                       lock_id_q;
  logic                       last_q;
  logic                       err_q;
  logic [MAX_OUTSTANDING-1:0] id_fifo_q;
  logic [PTR_W-1:0]           rd_ptr_q;
  logic [PTR_W-1:0]           wr_ptr_q;
  logic [CNT_W-1:0]           count_q;

  logic sel;
  logic sel_req;
  logic push;
  logic pop;
  logic head;

  // Selection: a pending lock wins, otherwise the lone requester, otherwise
  // the one that was not granted last.
  always_comb begin
    sel = 1'b0;
    if (state_q == LOCKED) begin
      sel = lock_id_q;
    end else if (m0_req_i && m1_req_i) begin
      sel = ~last_q;
    end else if (m1_req_i) begin
      sel = 1'b1;
    end
  end

  assign sel_req = sel ? m1_req_i : m0_req_i;

  // Only registered count feeds s_req_o, so a pop frees a slot next cycle.
  assign s_req_o  = rst_ni & sel_req & (count_q < CNT_MAX);
  assign push     = s_req_o & s_gnt_i;
  assign m0_gnt_o = push & ~sel;
  assign m1_gnt_o = push & sel;

  always_comb begin
    s_addr_o  = '0;
    s_we_o    = 1'b0;
    s_be_o    = '0;
    s_wdata_o = '0;
    if (sel_req) begin
      s_addr_o  = sel ? m1_addr_i  : m0_addr_i;
      s_we_o    = sel ? m1_we_i    : m0_we_i;
      s_be_o    = sel ? m1_be_i    : m0_be_i;
      s_wdata_o = sel ? m1_wdata_i : m0_wdata_i;
    end
  end

  // Response routing from the FIFO head; a response with no ID goes nowhere.
  assign head        = id_fifo_q[rd_ptr_q];
  assign pop         = rst_ni & s_rvalid_i & (count_q != '0);
  assign m0_rvalid_o = pop & ~head;
  assign m1_rvalid_o = pop & head;
  assign m0_rdata_o  = s_rdata_i;
  assign m1_rdata_o  = s_rdata_i;
  assign err_o       = rst_ni & err_q;

  // Arbiter state, lock capture, ID FIFO and sticky error.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      lock_id_q <= 1'b0;
      last_q    <= 1'b1;
      err_q     <= 1'b0;
      id_fifo_q <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (s_req_o && !s_gnt_i) begin
            state_q   <= LOCKED;
            lock_id_q <= sel;
          end
        end
        LOCKED: begin
          if (push) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (push) begin
        id_fifo_q[wr_ptr_q] <= sel;
        wr_ptr_q            <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        last_q              <= sel;
      end

      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
      end

      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase

      if (s_rvalid_i && (count_q == '0)) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_core_mem_arbiter.sv
module tb_core_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        m0_req_i, m1_req_i, m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o;
  logic [31:0] m0_addr_i, m1_addr_i, m0_wdata_i, m1_wdata_i, m0_rdata_o, m1_rdata_o;
  logic        m0_we_i, m1_we_i;
  logic [3:0]  m0_be_i, m1_be_i;
  logic        s_req_o, s_gnt_i, s_rvalid_i, s_we_o, err_o;
  logic [31:0] s_addr_o, s_wdata_o, s_rdata_i;
  logic [3:0]  s_be_o;

  int n_cmp = 0;
  int n_err = 0;
  logic exp_q[$];

  always #5 clk_i = ~clk_i;

  core_mem_arbiter dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m0_req_i(m0_req_i), .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o),
    .m0_addr_i(m0_addr_i), .m0_we_i(m0_we_i), .m0_be_i(m0_be_i),
    .m0_wdata_i(m0_wdata_i), .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req_i), .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o),
    .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i),
    .m1_wdata_i(m1_wdata_i), .m1_rdata_o(m1_rdata_o),
    .s_req_o(s_req_o), .s_gnt_i(s_gnt_i), .s_rvalid_i(s_rvalid_i),
    .s_addr_o(s_addr_o), .s_we_o(s_we_o), .s_be_o(s_be_o),
    .s_wdata_o(s_wdata_o), .s_rdata_i(s_rdata_i), .err_o(err_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  // Grant check for this cycle; records the expected owner in the scoreboard.
  task automatic expect_grant(input logic id);
    check("s_req", s_req_o, 1'b1);
    check("gnt_m0", m0_gnt_o, !id);
    check("gnt_m1", m1_gnt_o, id);
    check("s_addr", s_addr_o, id ? m1_addr_i : m0_addr_i);
    check("s_wdata", s_wdata_o, id ? m1_wdata_i : m0_wdata_i);
    exp_q.push_back(id);
  endtask

  // Compare response routing against the oldest expected owner.
  task automatic check_pop(input logic [31:0] data);
    logic id;
    check("sb_nonempty", exp_q.size() > 0, 1'b1);
    if (exp_q.size() > 0) begin
      id = exp_q.pop_front();
      check("rvalid_m0", m0_rvalid_o, !id);
      check("rvalid_m1", m1_rvalid_o, id);
      check("rdata", id ? m1_rdata_o : m0_rdata_o, data);
    end
  endtask

  task automatic respond(input logic [31:0] data);
    s_rvalid_i = 1'b1;
    s_rdata_i  = data;
    #1;
    check_pop(data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_ni = 1'b0;
    m0_req_i = 1'b1; m1_req_i = 1'b1;
    m0_addr_i = 32'h100; m1_addr_i = 32'h300;
    m0_we_i = 1'b0; m1_we_i = 1'b1;
    m0_be_i = 4'hF; m1_be_i = 4'h3;
    m0_wdata_i = 32'h1111_0000; m1_wdata_i = 32'h2222_0000;
    s_gnt_i = 1'b1; s_rvalid_i = 1'b1; s_rdata_i = '0;

    // Reset: everything quiet even with all inputs active.
    #1;
    check("rst_s_req", s_req_o, 1'b0);
    check("rst_gnt0", m0_gnt_o, 1'b0);
    check("rst_rvalid1", m1_rvalid_o, 1'b0);
    check("rst_err", err_o, 1'b0);
    cyc();
    rst_ni = 1'b1;
    m0_req_i = 1'b0; m1_req_i = 1'b0; s_gnt_i = 1'b0; s_rvalid_i = 1'b0;
    #1;
    check("idle_s_req", s_req_o, 1'b0);
    check("idle_s_addr", s_addr_o, 32'h0);
    cyc();

    // Single requester: m0 read, response two cycles later.
    m0_req_i = 1'b1; s_gnt_i = 1'b1;
    #1;
    expect_grant(1'b0);
    check("single_we", s_we_o, 1'b0);
    check("single_be", s_be_o, 4'hF);
    cyc();
    m0_req_i = 1'b0; s_gnt_i = 1'b0;
    #1;
    check("single_gap_req", s_req_o, 1'b0);
    cyc();
    respond(32'hDEADBEEF);
    cyc();
    s_rvalid_i = 1'b0;

    // Response with nothing outstanding: dropped, sticky error.
    s_rvalid_i = 1'b1;
    #1;
    check("orphan_rv0", m0_rvalid_o, 1'b0);
    check("orphan_rv1", m1_rvalid_o, 1'b0);
    cyc();
    s_rvalid_i = 1'b0;
    #1;
    check("err_set", err_o, 1'b1);
    cyc();
    check("err_sticky", err_o, 1'b1);

    // Reset clears error and tie-break history.
    rst_ni = 1'b0; m0_req_i = 1'b1; m1_req_i = 1'b1; s_gnt_i = 1'b1;
    #1;
    check("rst2_s_req", s_req_o, 1'b0);
    check("rst2_err", err_o, 1'b0);
    cyc();
    rst_ni = 1'b1; m0_req_i = 1'b0; m1_req_i = 1'b0; s_gnt_i = 1'b0;
    #1;
    check("rst2_err_after", err_o, 1'b0);
    cyc();

    // Contention: alternating grants with in-order responses in flight.
    m0_addr_i = 32'h200; m0_we_i = 1'b1; m0_wdata_i = 32'hAAAA_0001;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] cnt;
      cnt = 32'(i);
      m0_req_i = 1'b1; m1_req_i = 1'b1; s_gnt_i = 1'b1;
      s_rvalid_i = (i > 0); s_rdata_i = 32'hA000 + cnt;
      #1;
      if (i > 0) check_pop(32'hA000 + cnt);
      expect_grant(cnt[0]);
      cyc();
    end
    m0_req_i = 1'b0; m1_req_i = 1'b0; s_gnt_i = 1'b0;
    respond(32'hA004);
    cyc();
    s_rvalid_i = 1'b0;

    // Lock: stalled m1 selection survives m0 joining (m0 would win the tie).
    m1_req_i = 1'b1; m1_addr_i = 32'h400;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("lock_s_req", s_req_o, 1'b1);
      check("lock_s_addr", s_addr_o, 32'h400);
      check("lock_no_gnt", m1_gnt_o, 1'b0);
      cyc();
    end
    m0_req_i = 1'b1;
    #1;
    check("lock_hold_addr", s_addr_o, 32'h400);
    check("lock_m0_nogo", m0_gnt_o, 1'b0);
    cyc();
    s_gnt_i = 1'b1;
    #1;
    expect_grant(1'b1);
    cyc();
    m1_req_i = 1'b0;
    #1;
    check("lock_m1_once", m1_gnt_o, 1'b0);
    expect_grant(1'b0);
    cyc();
    m0_req_i = 1'b0; s_gnt_i = 1'b0;
    respond(32'hB001);
    cyc();
    respond(32'hB000);
    cyc();
    s_rvalid_i = 1'b0;

    // Full FIFO: requests stall until the cycle after a pop.
    m0_req_i = 1'b1; m0_addr_i = 32'h500; s_gnt_i = 1'b1;
    #1; expect_grant(1'b0); cyc();
    expect_grant(1'b0); cyc();
    for (int i = 0; i < 2; i++) begin
      check("full_s_req", s_req_o, 1'b0);
      check("full_gnt", m0_gnt_o, 1'b0);
      cyc();
    end
    respond(32'hC000);
    check("full_pop_same_cycle", s_req_o, 1'b0);
    cyc();
    respond(32'hC001);
    expect_grant(1'b0);
    cyc();
    s_rvalid_i = 1'b0;
    #1; expect_grant(1'b0); cyc();
    check("full_again", s_req_o, 1'b0);
    m0_req_i = 1'b0; s_gnt_i = 1'b0;
    cyc();
    respond(32'hC002);
    cyc();
    respond(32'hC003);
    cyc();
    s_rvalid_i = 1'b0;
    #1;
    check("sb_drained", exp_q.size(), 0);
    check("err_clear_end", err_o, 1'b0);

    // Draining past empty trips the error again.
    s_rvalid_i = 1'b1;
    #1;
    check("orphan2_rv0", m0_rvalid_o, 1'b0);
    cyc();
    s_rvalid_i = 1'b0;
    #1;
    check("err_set2", err_o, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
